// File: rtl/spi_cmd_sequencer_if.sv
// spi_cmd_sequencer_if: PCI-side command/read FIFO signals plus the
// start/done handshake towards the SPI master, bundled for one connection.
interface spi_cmd_sequencer_if;
    logic        CMD_WR_I;
    logic [31:0] CMD_DATA_I;
    logic [1:0]  CMD_SEL_I;
    logic        CMD_FULL_O;
    logic        RD_EN_I;
    logic [31:0] RD_DATA_O;
    logic        RD_EMPTY_O;
    logic        BUSY_O;
    logic [1:0]  ERR_O;
    logic        ERR_CLR_I;
    logic [31:0] SPI_I_O;
    logic [1:0]  SPI_SEL_O;
    logic        SPI_STAR_O;
    logic        SPI_DONE_I;
    logic [31:0] SPI_O_I;

    // sequencer side
    modport slave (
        input  CMD_WR_I, CMD_DATA_I, CMD_SEL_I, RD_EN_I, ERR_CLR_I,
               SPI_DONE_I, SPI_O_I,
        output CMD_FULL_O, RD_DATA_O, RD_EMPTY_O, BUSY_O, ERR_O,
               SPI_I_O, SPI_SEL_O, SPI_STAR_O
    );

    // PCI host and SPI master side
    modport master (
        output CMD_WR_I, CMD_DATA_I, CMD_SEL_I, RD_EN_I, ERR_CLR_I,
               SPI_DONE_I, SPI_O_I,
        input  CMD_FULL_O, RD_DATA_O, RD_EMPTY_O, BUSY_O, ERR_O,
               SPI_I_O, SPI_SEL_O, SPI_STAR_O
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues 32-bit SPI command words with a chip-select index
// and issues them one at a time over the SPI master's start/done handshake.
// Read-back commands (data[3:0] == 4'b1110) have their result captured into a
// first-word-fall-through read FIFO for the PCI side to drain.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a queued command while the master has done low
// LOAD     | command word/select presented to the master, one setup cycle
// START    | STAR high, waiting for the master to raise done
// CAPTURE  | read-back result held by the master until the read FIFO has room
// RELEASE  | STAR low, waiting for the master to drop done
module spi_cmd_sequencer #(
    parameter int CMD_DEPTH = 16,
    parameter int RD_DEPTH  = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic               BOARD_CLOCK,
    input  logic               RST_N,
    spi_cmd_sequencer_if.slave bus
);
    localparam int              CAW      = $clog2(CMD_DEPTH);
    localparam int              RAW      = $clog2(RD_DEPTH);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [3:0]      RB_CODE  = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_CAPTURE,
        ST_RELEASE
    } state_t;

    state_t state;
    state_t next_state;

    // command FIFO: {sel, data}
    logic [33:0]  cmd_mem [CMD_DEPTH];
    logic [CAW:0] cmd_wr_ptr;
    logic [CAW:0] cmd_rd_ptr;
    logic [CAW:0] cmd_wr_ptr_nxt;
    logic [CAW:0] cmd_rd_ptr_nxt;
    logic         cmd_empty;
    logic         cmd_full;
    logic         cmd_push;
    logic         cmd_pop;
    logic [33:0]  cmd_head;

    // read FIFO
    logic [31:0]  rd_mem [RD_DEPTH];
    logic [RAW:0] rd_wr_ptr;
    logic [RAW:0] rd_rd_ptr;
    logic [RAW:0] rd_wr_ptr_nxt;
    logic [RAW:0] rd_rd_ptr_nxt;
    logic         rd_empty;
    logic         rd_full;
    logic         rd_push;
    logic         rd_pop;

    logic          done_m;
    logic          done_s;
    logic [TW-1:0] tmr;
    logic          tmo_evt;
    logic          rb_flag;
    logic [31:0]   spi_i_q;
    logic [1:0]    spi_sel_q;
    logic          star_q;
    logic [1:0]    err_q;
    logic [1:0]    err_set;

    // ------------------------------------------------------------------
    // command FIFO
    // ------------------------------------------------------------------
    assign cmd_push       = bus.CMD_WR_I & ~cmd_full;
    assign cmd_wr_ptr_nxt = cmd_wr_ptr + {{CAW{1'b0}}, cmd_push};
    assign cmd_rd_ptr_nxt = cmd_rd_ptr + {{CAW{1'b0}}, cmd_pop};
    assign cmd_head       = cmd_mem[cmd_rd_ptr[CAW-1:0]];

    // Command storage; validity is defined by the pointers, so no reset.
    always_ff @(posedge BOARD_CLOCK) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr[CAW-1:0]] <= {bus.CMD_SEL_I, bus.CMD_DATA_I};
        end
    end

    // Command pointers and registered empty/full flags.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_empty  <= 1'b1;
            cmd_full   <= 1'b0;
        end else begin
            cmd_wr_ptr <= cmd_wr_ptr_nxt;
            cmd_rd_ptr <= cmd_rd_ptr_nxt;
            cmd_empty  <= (cmd_wr_ptr_nxt == cmd_rd_ptr_nxt);
            cmd_full   <= (cmd_wr_ptr_nxt[CAW] != cmd_rd_ptr_nxt[CAW]) &&
                          (cmd_wr_ptr_nxt[CAW-1:0] == cmd_rd_ptr_nxt[CAW-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // read FIFO
    // ------------------------------------------------------------------
    assign rd_pop        = bus.RD_EN_I & ~rd_empty;
    assign rd_wr_ptr_nxt = rd_wr_ptr + {{RAW{1'b0}}, rd_push};
    assign rd_rd_ptr_nxt = rd_rd_ptr + {{RAW{1'b0}}, rd_pop};

    // Read-back result storage; validity is defined by the pointers.
    always_ff @(posedge BOARD_CLOCK) begin
        if (rd_push) begin
            rd_mem[rd_wr_ptr[RAW-1:0]] <= bus.SPI_O_I;
        end
    end

    // Read pointers and registered empty/full flags.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            rd_wr_ptr <= '0;
            rd_rd_ptr <= '0;
            rd_empty  <= 1'b1;
            rd_full   <= 1'b0;
        end else begin
            rd_wr_ptr <= rd_wr_ptr_nxt;
            rd_rd_ptr <= rd_rd_ptr_nxt;
            rd_empty  <= (rd_wr_ptr_nxt == rd_rd_ptr_nxt);
            rd_full   <= (rd_wr_ptr_nxt[RAW] != rd_rd_ptr_nxt[RAW]) &&
                         (rd_wr_ptr_nxt[RAW-1:0] == rd_rd_ptr_nxt[RAW-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // handshake FSM
    // ------------------------------------------------------------------

    // Done synchronizer; resets high so nothing issues until the master
    // is seen idle after reset.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            done_m <= 1'b1;
            done_s <= 1'b1;
        end else begin
            done_m <= bus.SPI_DONE_I;
            done_s <= done_m;
        end
    end

    // State register.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the FIFO pop/push and timeout strobes.
    always_comb begin
        next_state = state;
        cmd_pop    = 1'b0;
        rd_push    = 1'b0;
        tmo_evt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!cmd_empty && !done_s) begin
                    next_state = ST_LOAD;
                    cmd_pop    = 1'b1;
                end
            end
            ST_LOAD: begin
                next_state = ST_START;
            end
            ST_START: begin
                if (done_s) begin
                    next_state = rb_flag ? ST_CAPTURE : ST_RELEASE;
                end else if (tmr == '0) begin
                    tmo_evt    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (!rd_full) begin
                    rd_push    = 1'b1;
                    next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!done_s) begin
                    next_state = ST_IDLE;
                end else if (tmr == '0) begin
                    tmo_evt    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Per-phase timeout down-counter: reloads on every state change and
    // only counts while waiting on the master.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            tmr <= TMR_LOAD;
        end else if (next_state != state) begin
            tmr <= TMR_LOAD;
        end else if ((state == ST_START || state == ST_RELEASE) && tmr != '0) begin
            tmr <= tmr - TW'(1);
        end
    end

    // Command word and select are captured as the head is popped, so they are
    // stable a full cycle before STAR rises; STAR follows the next state.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            spi_i_q   <= '0;
            spi_sel_q <= '0;
            rb_flag   <= 1'b0;
            star_q    <= 1'b0;
        end else begin
            if (cmd_pop) begin
                spi_i_q   <= cmd_head[31:0];
                spi_sel_q <= cmd_head[33:32];
                rb_flag   <= (cmd_head[3:0] == RB_CODE);
            end
            star_q <= (next_state == ST_START) || (next_state == ST_CAPTURE);
        end
    end

    // Sticky errors; a new event in the clearing cycle keeps its bit set.
    assign err_set = {bus.CMD_WR_I & cmd_full, tmo_evt};

    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= '0;
        end else begin
            err_q <= err_set | (err_q & ~{2{bus.ERR_CLR_I}});
        end
    end

    assign bus.CMD_FULL_O = cmd_full;
    assign bus.RD_EMPTY_O = rd_empty;
    assign bus.RD_DATA_O  = rd_empty ? 32'h0 : rd_mem[rd_rd_ptr[RAW-1:0]];
    assign bus.BUSY_O     = (state != ST_IDLE) || !cmd_empty;
    assign bus.ERR_O      = err_q;
    assign bus.SPI_I_O    = spi_i_q;
    assign bus.SPI_SEL_O  = spi_sel_q;
    assign bus.SPI_STAR_O = star_q;
endmodule
